pipe_ctrl: RTL

Central pipeline sequencer for the five-stage ARM core. It replaces the tied-off `freeze`/`flush` nets at the top level with real control. Every cycle it decides whether the stage registers advance, hold, take a bubble or are flushed. It resolves three sources, in priority order: a multi-cycle data-memory access (with a timeout watchdog), a taken branch from EXE, and RAW data hazards between ID and the EXE/MEM destinations.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_detect.sv | 47 ++++
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencer:
//   state_t      - sequencer FSM states (RUN, MEM_WAIT)
//   REG_W_DEF    - default register-address width
//   CNT_W        - width of the optional performance counters
//   sat_inc32()  - saturating increment used by the performance counters
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int REG_W_DEF = 4;
    localparam int CNT_W     = 32;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc32(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipe_hazard_detect
// Purely combinational RAW hazard comparator between the instruction in ID
// and the write-back destinations of the instructions in EXE and MEM.
// Kept separate so a forwarding unit can reuse the same comparison.
//
// Ports:
//   i_id_valid    - ID holds a real instruction
//   i_id_src1     - first source register
//   i_id_src2     - second source register
//   i_id_use_src2 - instruction actually reads src2
//   i_exe_wb_en   - EXE instruction writes back
//   i_exe_dest    - EXE destination register
//   i_mem_wb_en   - MEM instruction writes back
//   i_mem_dest    - MEM destination register
//   o_haz         - ID depends on a result not yet written back
// ---------------------------------------------------------------------------
module pipe_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_src1,
    input  logic [REG_W-1:0] i_id_src2,
    input  logic             i_id_use_src2,
    input  logic             i_exe_wb_en,
    input  logic [REG_W-1:0] i_exe_dest,
    input  logic             i_mem_wb_en,
    input  logic [REG_W-1:0] i_mem_dest,
    output logic             o_haz
);

    logic w_src1_hit;
    logic w_src2_hit;

    assign w_src1_hit = (i_exe_wb_en && (i_id_src1 == i_exe_dest)) ||
                        (i_mem_wb_en && (i_id_src1 == i_mem_dest));

    // src2 only matters when the instruction actually reads it.
    assign w_src2_hit = i_id_use_src2 &&
                        ((i_exe_wb_en && (i_id_src2 == i_exe_dest)) ||
                         (i_mem_wb_en && (i_id_src2 == i_mem_dest)));

    assign o_haz = i_id_valid && (w_src1_hit || w_src2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline sequencer for the five-stage core. Each cycle it decides
// whether the stage registers advance, hold, take a bubble or are flushed.
// Priority: memory stall > branch flush > RAW hazard.
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_count saturating performance counters (ports and registers).
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   id_*              - ID-stage source operands and valid
//   exe_wb_en/dest    - EXE write-back destination
//   mem_wb_en/dest    - MEM write-back destination
//   exe_branch_taken  - branch resolved taken in EXE
//   exe_mem_req       - load/store presented to data memory
//   mem_ready         - data memory completes the access this cycle
//   stall_all         - every stage register holds
//   freeze            - PC and IF/ID hold
//   bubble            - ID/EXE loads a NOP
//   flush             - IF/ID and ID/EXE clear
//   mem_err           - sticky: an access timed out
//   stall_cycles      - (PIPE_CTRL_PERF_EN) cycles with freeze=1
//   flush_count       - (PIPE_CTRL_PERF_EN) cycles with flush=1
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int REG_W       = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src2,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             exe_branch_taken,
    input  logic             exe_mem_req,
    input  logic             mem_ready,
    output logic             stall_all,
    output logic             freeze,
    output logic             bubble,
    output logic             flush,
    output logic             mem_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    // Guard against a zero-width counter if MEM_TIMEOUT is set to 0.
    localparam int WCNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] TMO = WCNT_W'(MEM_TIMEOUT);

    state_t            r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_mem_err;

    logic w_haz;
    logic w_mem_stall;
    logic w_stall;
    logic w_flush;
    logic w_bubble;

    pipe_hazard_detect #(
        .REG_W (REG_W)
    ) u_haz (
        .i_id_valid    (id_valid),
        .i_id_src1     (id_src1),
        .i_id_src2     (id_src2),
        .i_id_use_src2 (id_use_src2),
        .i_exe_wb_en   (exe_wb_en),
        .i_exe_dest    (exe_dest),
        .i_mem_wb_en   (mem_wb_en),
        .i_mem_dest    (mem_dest),
        .o_haz         (w_haz)
    );

    // Memory stall: in RUN a request that is not immediately ready stalls;
    // in MEM_WAIT we keep stalling until ready or the watchdog expires.
    always_comb begin
        w_mem_stall = 1'b0;
        case (r_state)
            RUN:      w_mem_stall = exe_mem_req && !mem_ready;
            MEM_WAIT: w_mem_stall = !mem_ready && (r_wcnt != TMO);
            default:  w_mem_stall = 1'b0;
        endcase
    end

    // All control outputs are forced low while reset is asserted. A branch
    // seen during a stall stays in the frozen EXE register, so it is
    // naturally flushed on the release cycle.
    assign w_stall  = !rst && w_mem_stall;
    assign w_flush  = !rst && exe_branch_taken && !w_mem_stall;
    assign w_bubble = !rst && w_haz && !exe_branch_taken && !w_mem_stall;

    assign stall_all = w_stall;
    assign flush     = w_flush;
    assign bubble    = w_bubble;
    assign freeze    = w_stall || w_bubble;
    assign mem_err   = r_mem_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_wcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (exe_mem_req && !mem_ready) begin
                        r_state <= MEM_WAIT;
                        r_wcnt  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end else if (r_wcnt == TMO) begin
                        r_state   <= RUN;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (freeze) begin
                r_stall_cycles <= sat_inc32(r_stall_cycles);
            end
            if (w_flush) begin
                r_flush_count <= sat_inc32(r_flush_count);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule
